sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
Shares the single SRAM-like memory port between the fetch (instruction) and memory-stage (data) requesters of the 5-stage MIPS core. It allows one outstanding transaction at a time, with fixed data-over-instruction priority. It holds returned read data until the pipeline advances. It produces a memory stall that the hazard unit ORs into its stall/flush equations, alongside the divider stall.

Parameters:
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch wants an instruction; held while stall_o
inst_addr  in  AW  fetch address (PC)
inst_rdata  out  DW  instruction word, registered
data_req  in  1  memory-stage access pending; held while stall_o
data_wr  in  1  1 = store, 0 = load
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  AW  data address
data_wdata  in  DW  store data
data_rdata  out  DW  load data, registered
ext_stall  in  1  other pipeline stall (e.g. divider busy)
stall_o  out  1  memory stall to the hazard unit
mem_req  out  1  request to the memory port
mem_wr  out  1  write enable
mem_size  out  2  access size
mem_addr  out  AW  address
mem_wdata  out  DW  write data
mem_addr_ok  in  1  memory accepted the request this cycle
mem_data_ok  in  1  response valid this cycle
mem_rdata  in  DW  read data

Behaviour:
- FSM states: IDLE, D_ADDR, D_WAIT, I_ADDR, I_WAIT. Reset enters IDLE.
- Done flags: i_done and d_done, both 0 on reset.
- Reset values: inst_rdata = 0, data_rdata = 0, mem_req = 0, stall_o = 0. Reset mid-transaction abandons the transaction; any late mem_data_ok after reset is ignored while in IDLE.
- IDLE transitions:
  - Go to D_ADDR if data_req & ~d_done.
  - Otherwise go to I_ADDR if inst_req & ~i_done.
  - Data has priority when both are pending.
- Address latching: at the IDLE exit, the selected requester's addr/wr/size/wdata are latched into registers. mem_* outputs drive from these registers, so they are stable across the whole handshake.
- mem_req = 1 only in D_ADDR and I_ADDR. In I_ADDR, mem_wr = 0 and mem_size = 2.
- D_ADDR → D_WAIT, and I_ADDR → I_WAIT, on mem_addr_ok. Otherwise stay, keeping mem_req high.
- D_WAIT/I_WAIT → IDLE on mem_data_ok. mem_data_ok outside WAIT states is ignored.
- Data capture on mem_data_ok in D_WAIT:
  - If not a store, data_rdata <= mem_rdata.
  - d_done <= 1.
- Instruction capture on mem_data_ok in I_WAIT: inst_rdata <= mem_rdata; i_done <= 1.
- Return to IDLE is never combined with a new issue in the same cycle. Minimum per-access latency is IDLE(1) + ADDR(≥1) + WAIT(≥1).
- stall_o is combinational: (inst_req & ~i_done) | (data_req & ~d_done).
- Pipeline advance is defined as ~stall_o & ~ext_stall. On advance, both i_done and d_done clear on the next edge.
- If ext_stall holds, the done flags stay set. The fetch/data access is not re-issued and the rdata registers keep their values.
- A done flag set in the same cycle as an advance takes the set; in practice this cannot happen, since stall_o is high in that cycle.
- A requester whose req is low never stalls the pipeline.
- Back-to-back case: with both requests pending, the data access completes first, then the instruction access is issued. stall_o stays high until both done flags are set.

Test Plan:
- Fetch only: inst_req = 1, inst_addr = 0xBFC00000, addr_ok after 1 cycle, data_ok 2 cycles later with rdata = 0x24080001 → mem_req high 2 cycles; inst_rdata = 0x24080001; stall_o falls the cycle after data_ok; i_done clears next edge.
- Simultaneous: inst_req and data_req (load, addr 0x80000010) asserted together → data transaction issues first, instruction next; stall_o stays 1 until both complete; data_rdata and inst_rdata hold their respective values.
- Store: data_wr = 1, size = 0, addr 0x80000003, wdata = 0xAB → mem_wr = 1, mem_size = 0; mem_addr/mem_wdata stable until addr_ok; data_rdata unchanged.
- ext_stall held 3 cycles after an instruction completes → no second mem_req; inst_rdata stable; on ext_stall release, i_done clears and the next fetch issues.
- Reset asserted in I_WAIT, then mem_data_ok arrives after reset release → state IDLE, inst_rdata = 0, response ignored; a fresh request then issues normally.
- addr_ok delayed 5 cycles → mem_req and mem_addr held constant for all 5 cycles; single transaction, no duplicate issue.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_arbiter
// Purpose  : Shares one SRAM-like memory port between the instruction fetch
//            and memory-stage data requesters of a 5-stage MIPS pipeline.
//            At most one transaction is outstanding at a time, and data has
//            fixed priority over instruction. Returned read data is held in
//            registers until the pipeline advances. A memory stall is
//            produced for the hazard unit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   clock, rising edge
//   resetn       in   1   asynchronous active-low reset
//   inst_req     in   1   fetch request (held while stall_o)
//   inst_addr    in   AW  fetch address (PC)
//   inst_rdata   out  DW  instruction word, registered
//   data_req     in   1   memory-stage request (held while stall_o)
//   data_wr      in   1   1 = store, 0 = load
//   data_size    in   2   0 = byte, 1 = half, 2 = word
//   data_addr    in   AW  data address
//   data_wdata   in   DW  store data
//   data_rdata   out  DW  load data, registered
//   ext_stall    in   1   other pipeline stall source (e.g. divider)
//   stall_o      out  1   memory stall to the hazard unit
//   mem_req      out  1   memory port request
//   mem_wr       out  1   memory port write enable
//   mem_size     out  2   memory port access size
//   mem_addr     out  AW  memory port address
//   mem_wdata    out  DW  memory port write data
//   mem_addr_ok  in   1   memory accepted the request this cycle
//   mem_data_ok  in   1   memory response valid this cycle
//   mem_rdata    in   DW  memory read data
// ============================================================================
module sram_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_rdata,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    input  logic          ext_stall,
    output logic          stall_o,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_addr_ok,
    input  logic          mem_data_ok,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_ADDR = 3'd1,
        D_WAIT = 3'd2,
        I_ADDR = 3'd3,
        I_WAIT = 3'd4
    } state_t;

    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_i_done;
    logic          r_d_done;

    // Latched request; the memory port is driven from these so it is
    // stable for the whole address/data handshake.
    logic [AW-1:0] r_addr;
    logic          r_wr;
    logic [1:0]    r_size;
    logic [DW-1:0] r_wdata;

    logic [DW-1:0] r_inst_rdata;
    logic [DW-1:0] r_data_rdata;

    logic          w_d_pend;
    logic          w_i_pend;
    logic          w_stall;
    logic          w_advance;
    logic          w_issue_d;
    logic          w_issue_i;
    logic          w_d_cap;
    logic          w_i_cap;

    // A requester only stalls while its access is still outstanding.
    assign w_d_pend  = data_req & ~r_d_done;
    assign w_i_pend  = inst_req & ~r_i_done;
    assign w_stall   = w_d_pend | w_i_pend;
    assign w_advance = ~w_stall & ~ext_stall;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode. A return to IDLE never issues in the
    // same cycle, so a new request is only evaluated from IDLE after the
    // done flags have been updated.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_issue_d   = 1'b0;
        w_issue_i   = 1'b0;
        w_d_cap     = 1'b0;
        w_i_cap     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_d_pend) begin
                    w_state_nxt = D_ADDR;
                    w_issue_d   = 1'b1;
                end else if (w_i_pend) begin
                    w_state_nxt = I_ADDR;
                    w_issue_i   = 1'b1;
                end
            end
            D_ADDR: begin
                if (mem_addr_ok) begin
                    w_state_nxt = D_WAIT;
                end
            end
            D_WAIT: begin
                if (mem_data_ok) begin
                    w_state_nxt = IDLE;
                    w_d_cap     = 1'b1;
                end
            end
            I_ADDR: begin
                if (mem_addr_ok) begin
                    w_state_nxt = I_WAIT;
                end
            end
            I_WAIT: begin
                if (mem_data_ok) begin
                    w_state_nxt = IDLE;
                    w_i_cap     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, loaded on the IDLE exit only
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_wdata <= '0;
        end else if (w_issue_d) begin
            r_addr  <= data_addr;
            r_wr    <= data_wr;
            r_size  <= data_size;
            r_wdata <= data_wdata;
        end else if (w_issue_i) begin
            r_addr  <= inst_addr;
            r_wr    <= 1'b0;
            r_size  <= c_SIZE_WORD;
            r_wdata <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Done flags: set on response capture, cleared when the pipeline
    // advances. A set wins over a simultaneous clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_d_done <= 1'b0;
            r_i_done <= 1'b0;
        end else begin
            if (w_d_cap) begin
                r_d_done <= 1'b1;
            end else if (w_advance) begin
                r_d_done <= 1'b0;
            end

            if (w_i_cap) begin
                r_i_done <= 1'b1;
            end else if (w_advance) begin
                r_i_done <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data holding registers. A store response carries no useful
    // data, so the load register is left untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            if (w_i_cap) begin
                r_inst_rdata <= mem_rdata;
            end
            if (w_d_cap && !r_wr) begin
                r_data_rdata <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req    = (r_state == D_ADDR) || (r_state == I_ADDR);
    assign mem_wr     = r_wr;
    assign mem_size   = r_size;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

    assign inst_rdata = r_inst_rdata;
    assign data_rdata = r_data_rdata;
    assign stall_o    = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_arbiter
// Purpose  : Self-checking bench for sram_bus_arbiter. A memory responder
//            with programmable address/data latency serves the port; every
//            issued transaction is checked against a scoreboard queue filled
//            when the stimulus is driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] data_rdata;
    logic          ext_stall;
    logic          stall_o;
    logic          mem_req;
    logic          mem_wr;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok = 1'b0;
    logic          mem_data_ok = 1'b0;
    logic [DW-1:0] mem_rdata   = '0;

    sram_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .ext_stall   (ext_stall),
        .stall_o     (stall_o),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [1:0]  dsize;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        int          alat;
        int          dlat;
        logic [31:0] irdata;
        logic [31:0] drdata;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
    } vec_t;

    txn_t        sb_q[$];
    txn_t        sb_t;
    vec_t        vecs[5];
    vec_t        vpost;

    int          n_cmp = 0;
    int          n_err = 0;

    // Responder controls
    int          addr_lat   = 0;
    int          data_lat   = 1;
    bit          late_dok   = 1'b0;
    logic [31:0] cur_iaddr  = '0;
    logic [31:0] cur_irdata = '0;
    logic [31:0] cur_drdata = '0;
    int          a_cnt      = 0;
    int          d_cnt      = 0;
    bit          wait_data  = 1'b0;
    logic [31:0] lat_addr   = '0;
    logic [31:0] hold_addr  = '0;
    logic [31:0] hold_wdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic [31:0] a, input logic w, input logic [1:0] s,
                            input logic [31:0] d);
        txn_t t;
        t.addr  = a;
        t.wr    = w;
        t.size  = s;
        t.wdata = d;
        sb_q.push_back(t);
    endtask

    // Memory responder and scoreboard checker, evaluated on the falling edge
    always @(negedge clk) begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        if (late_dok) begin
            mem_data_ok = 1'b1;
            mem_rdata   = 32'hFFFF_FFFF;
        end
        if (!resetn) begin
            a_cnt     = 0;
            wait_data = 1'b0;
        end else if (wait_data) begin
            chk("single_outstanding", {31'b0, mem_req}, 32'd0);
            if (d_cnt >= data_lat) begin
                mem_data_ok = 1'b1;
                mem_rdata   = (lat_addr == cur_iaddr) ? cur_irdata : cur_drdata;
                wait_data   = 1'b0;
            end else begin
                d_cnt++;
            end
        end else if (mem_req) begin
            if (a_cnt == 0) begin
                hold_addr  = mem_addr;
                hold_wdata = mem_wdata;
            end else begin
                chk("addr_hold", mem_addr, hold_addr);
                chk("wdata_hold", mem_wdata, hold_wdata);
            end
            if (a_cnt >= addr_lat) begin
                mem_addr_ok = 1'b1;
                wait_data   = 1'b1;
                d_cnt       = 1;
                a_cnt       = 0;
                lat_addr    = mem_addr;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got issue at 0x%08h required none", mem_addr);
                end else begin
                    sb_t = sb_q.pop_front();
                    chk("sb_addr", mem_addr, sb_t.addr);
                    chk("sb_wr", {31'b0, mem_wr}, {31'b0, sb_t.wr});
                    chk("sb_size", {30'b0, mem_size}, {30'b0, sb_t.size});
                    if (sb_t.wr) chk("sb_wdata", mem_wdata, sb_t.wdata);
                end
            end else begin
                a_cnt++;
            end
        end
    end

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (stall_o && k < 60);
        if (stall_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: stall_o got 1 required 0", name);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        addr_lat   = v.alat;
        data_lat   = v.dlat;
        cur_iaddr  = v.iaddr;
        cur_irdata = v.irdata;
        cur_drdata = v.drdata;
        if (v.dreq) push_txn(v.daddr, v.dwr, v.dsize, v.dwdata);
        if (v.ireq) push_txn(v.iaddr, 1'b0, 2'd2, 32'h0);
        inst_req   = v.ireq;
        inst_addr  = v.iaddr;
        data_req   = v.dreq;
        data_wr    = v.dwr;
        data_size  = v.dsize;
        data_addr  = v.daddr;
        data_wdata = v.dwdata;
        #1;
        chk({name, "_stall_rise"}, {31'b0, stall_o}, {31'b0, v.ireq | v.dreq});
        wait_idle(name);
        chk({name, "_inst_rdata"}, inst_rdata, v.exp_i);
        chk({name, "_data_rdata"}, data_rdata, v.exp_d);
        inst_req = 1'b0;
        data_req = 1'b0;
        data_wr  = 1'b0;
    endtask

    initial begin
        // ireq iaddr dreq dwr dsize daddr dwdata alat dlat irdata drdata exp_i exp_d
        vecs[0] = '{1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1, 2,
                    32'h2408_0001, 32'h0, 32'h2408_0001, 32'h0};
        vecs[1] = '{1'b1, 32'hBFC0_0004, 1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0, 0, 1,
                    32'h8C09_0010, 32'hDEAD_BEEF, 32'h8C09_0010, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB, 2, 1,
                    32'h0, 32'h1111_1111, 32'h8C09_0010, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 2'd1, 32'h8000_0022, 32'h0, 5, 1,
                    32'h0, 32'h0000_CAFE, 32'h8C09_0010, 32'h0000_CAFE};
        vecs[4] = '{1'b1, 32'hBFC0_0008, 1'b1, 1'b1, 2'd2, 32'h8000_0100, 32'h1234_5678, 0, 3,
                    32'h3C1D_8000, 32'h2222_2222, 32'h3C1D_8000, 32'h0000_CAFE};
        vpost   = '{1'b1, 32'hBFC0_0024, 1'b1, 1'b0, 2'd2, 32'h8000_0040, 32'h0, 2, 1,
                    32'h0085_1021, 32'h55AA_55AA, 32'h0085_1021, 32'h55AA_55AA};

        resetn     = 1'b0;
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = '0;
        data_wdata = '0;
        ext_stall  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_inst_rdata", inst_rdata, 32'h0);
        chk("rst_data_rdata", data_rdata, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // ext_stall holds the done flag: no re-issue, data held
        @(negedge clk);
        ext_stall  = 1'b1;
        addr_lat   = 0;
        data_lat   = 1;
        cur_iaddr  = 32'hBFC0_000C;
        cur_irdata = 32'h27BD_FFE0;
        push_txn(32'hBFC0_000C, 1'b0, 2'd2, 32'h0);
        inst_req   = 1'b1;
        inst_addr  = 32'hBFC0_000C;
        wait_idle("ext_fetch");
        chk("ext_inst_rdata", inst_rdata, 32'h27BD_FFE0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("ext_no_reissue", {31'b0, mem_req}, 32'd0);
            chk("ext_hold_rdata", inst_rdata, 32'h27BD_FFE0);
            chk("ext_stall_low", {31'b0, stall_o}, 32'd0);
        end
        @(negedge clk);
        ext_stall  = 1'b0;
        inst_addr  = 32'hBFC0_0010;
        cur_iaddr  = 32'hBFC0_0010;
        cur_irdata = 32'hAFBF_001C;
        push_txn(32'hBFC0_0010, 1'b0, 2'd2, 32'h0);
        @(negedge clk);
        #1;
        chk("ext_release_stall", {31'b0, stall_o}, 32'd1);
        wait_idle("ext_next_fetch");
        chk("ext_next_rdata", inst_rdata, 32'hAFBF_001C);
        inst_req = 1'b0;

        // Reset while in I_WAIT, then a late response after reset release
        @(negedge clk);
        addr_lat   = 0;
        data_lat   = 30;
        cur_iaddr  = 32'hBFC0_0020;
        cur_irdata = 32'h0BAD_0BAD;
        push_txn(32'hBFC0_0020, 1'b0, 2'd2, 32'h0);
        inst_req   = 1'b1;
        inst_addr  = 32'hBFC0_0020;
        begin
            int k;
            k = 0;
            do begin
                @(negedge clk);
                #1;
                k++;
            end while (!wait_data && k < 20);
            if (!wait_data) begin
                n_cmp++;
                n_err++;
                $display("FAIL rst_accept timeout: addr_ok got 0 required 1");
            end
        end
        repeat (2) @(negedge clk);
        resetn   = 1'b0;
        inst_req = 1'b0;
        #1;
        chk("rst_mid_inst_rdata", inst_rdata, 32'h0);
        chk("rst_mid_data_rdata", data_rdata, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        late_dok = 1'b1;
        @(negedge clk);
        #1;
        late_dok = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("late_dok_inst_rdata", inst_rdata, 32'h0);
        chk("late_dok_stall", {31'b0, stall_o}, 32'd0);
        chk("late_dok_mem_req", {31'b0, mem_req}, 32'd0);

        apply(vpost, "post_rst");

        repeat (3) @(negedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 32'd0);
        chk("final_mem_req", {31'b0, mem_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
